// File: rtl/input_confirm_handshake.sv
// input_confirm_handshake: producer end of the CPU IData channel.
// When the CPU requests input, the core is stalled until the confirmation
// button is pressed and released. The switch value is then extended to word
// width and handed over with a one-cycle data_valid strobe.
//
// Optional build macro INPUT_CONFIRM_TIMEOUT_EN: if no press arrives within
// TIMEOUT_CYCLES cycles of arming, a zero word is delivered and timed_out
// pulses alongside data_valid. When the macro is undefined, ARMED waits
// indefinitely and timed_out stays 0.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no input instruction pending, core runs
//   ARMED   | core stalled, waiting for a fresh button press (LED on)
//   HELD    | switches captured, waiting for the button to be released
//   DELIVER | one cycle: data_out updated, data_valid high, stall released
//   DONE    | delivered, waiting for input_request to drop before re-arming
module input_confirm_handshake #(
   parameter int IO_WIDTH       = 16,
   parameter int WORD_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                 fast_clock,
   input  logic                 reset,
   input  logic                 input_request,
   input  logic                 sign_extend_input,
   input  logic [IO_WIDTH-1:0]  sw,
   input  logic                 confirmation,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 data_valid,
   output logic                 stall,
   output logic                 waiting,
   output logic                 timed_out
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_HELD    = 3'd2,
      S_DELIVER = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // The extension below needs at least one bit of headroom, and the timeout
   // needs at least two cycles so the load value is non-negative.
   if (WORD_SIZE <= IO_WIDTH || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("input_confirm_handshake: unsupported parameter combination");
   end

   state_t                state_q, state_d;
   logic [WORD_SIZE-1:0]  shadow_q, shadow_d;
   logic [WORD_SIZE-1:0]  data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d;
   logic                  stall_q, stall_d;
   logic                  waiting_q, waiting_d;
   logic                  timed_out_q, timed_out_d;
   logic                  conf_s1_q, conf_s2_q, conf_prev_q;
   logic                  conf_rise;
   logic                  tmr_done;
   logic [WORD_SIZE-1:0]  sw_ext;

   // Two-flop synchronizer plus one history flop for rising-edge detection.
   always_ff @(posedge fast_clock or negedge reset) begin
      if (!reset) begin
         conf_s1_q   <= 1'b0;
         conf_s2_q   <= 1'b0;
         conf_prev_q <= 1'b0;
      end else begin
         conf_s1_q   <= confirmation;
         conf_s2_q   <= conf_s1_q;
         conf_prev_q <= conf_s2_q;
      end
   end

   assign conf_rise = conf_s2_q & ~conf_prev_q;

   // Width extension of the raw switches, sign or zero per sign_extend_input.
   always_comb begin
      sw_ext = {{(WORD_SIZE-IO_WIDTH){sign_extend_input & sw[IO_WIDTH-1]}}, sw};
   end

`ifdef INPUT_CONFIRM_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;

   // Down-counter preloaded outside ARMED so it starts full on entry; reaching
   // zero marks the last ARMED cycle before the timeout delivery.
   always_comb begin
      tmr_d = tmr_q;
      if (state_q != S_ARMED) begin
         tmr_d = TMR_LOAD;
      end else if (tmr_q != '0) begin
         tmr_d = tmr_q - 1'b1;
      end
   end

   // Timeout counter register.
   always_ff @(posedge fast_clock or negedge reset) begin
      if (!reset) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end

   assign tmr_done = (state_q == S_ARMED) && (tmr_q == '0);
`else
   assign tmr_done = 1'b0;
`endif

   // Next-state and next-output decode; outputs follow the next state so
   // they line up with the state they describe.
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      data_out_d  = data_out_q;
      timed_out_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (input_request) state_d = S_ARMED;
         end
         S_ARMED: begin
            // Abort beats a same-cycle press; a press beats a same-cycle expiry.
            if (!input_request) begin
               state_d = S_IDLE;
            end else if (conf_rise) begin
               shadow_d = sw_ext;
               state_d  = S_HELD;
            end else if (tmr_done) begin
               shadow_d    = '0;
               data_out_d  = '0;
               timed_out_d = 1'b1;
               state_d     = S_DELIVER;
            end
         end
         S_HELD: begin
            if (!input_request) begin
               state_d = S_IDLE;
            end else if (!conf_s2_q) begin
               data_out_d = shadow_q;
               state_d    = S_DELIVER;
            end
         end
         S_DELIVER: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!input_request) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      stall_d      = (state_d == S_ARMED) || (state_d == S_HELD);
      waiting_d    = (state_d == S_ARMED);
      data_valid_d = (state_d == S_DELIVER);
   end

   // State and registered outputs.
   always_ff @(posedge fast_clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         shadow_q     <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         stall_q      <= 1'b0;
         waiting_q    <= 1'b0;
         timed_out_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         stall_q      <= stall_d;
         waiting_q    <= waiting_d;
         timed_out_q  <= timed_out_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign stall      = stall_q;
   assign waiting    = waiting_q;
   assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_input_confirm_handshake.sv
// Directed bench for input_confirm_handshake: reset, zero/sign extension,
// held-button rejection, aborts in ARMED and HELD, timeout (or its absence)
// and asynchronous reset while stalled.
module tb_input_confirm_handshake;

   logic        fast_clock;
   logic        reset;
   logic        input_request;
   logic        sign_extend_input;
   logic [15:0] sw;
   logic        confirmation;
   logic [31:0] data_out;
   logic        data_valid;
   logic        stall;
   logic        waiting;
   logic        timed_out;

   int total;
   int bad;

   input_confirm_handshake #(
      .IO_WIDTH       (16),
      .WORD_SIZE      (32),
      .TIMEOUT_CYCLES (10)
   ) u_dut (
      .fast_clock        (fast_clock),
      .reset             (reset),
      .input_request     (input_request),
      .sign_extend_input (sign_extend_input),
      .sw                (sw),
      .confirmation      (confirmation),
      .data_out          (data_out),
      .data_valid        (data_valid),
      .stall             (stall),
      .waiting           (waiting),
      .timed_out         (timed_out)
   );

   initial fast_clock = 1'b0;
   always #5 fast_clock = ~fast_clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge fast_clock);
      #1;
   endtask

   // Full press/release transaction starting from IDLE.
   task automatic txn(input logic [15:0] sw_v, input logic sext, input logic [31:0] exp);
      sw = sw_v;
      sign_extend_input = sext;
      input_request = 1'b1;
      tick();
      chk("arm_stall", {31'b0, stall}, 32'd1);
      chk("arm_waiting", {31'b0, waiting}, 32'd1);
      confirmation = 1'b1;
      tick(); tick();
      chk("press_sync_waiting", {31'b0, waiting}, 32'd1);
      tick();
      chk("held_waiting", {31'b0, waiting}, 32'd0);
      chk("held_stall", {31'b0, stall}, 32'd1);
      confirmation = 1'b0;
      tick(); tick();
      chk("release_sync_valid", {31'b0, data_valid}, 32'd0);
      chk("release_sync_stall", {31'b0, stall}, 32'd1);
      tick();
      chk("deliver_valid", {31'b0, data_valid}, 32'd1);
      chk("deliver_data", data_out, exp);
      chk("deliver_stall", {31'b0, stall}, 32'd0);
      chk("deliver_timed_out", {31'b0, timed_out}, 32'd0);
      tick();
      chk("done_valid", {31'b0, data_valid}, 32'd0);
      chk("done_stall", {31'b0, stall}, 32'd0);
      input_request = 1'b0;
      tick();
      chk("idle_hold_data", data_out, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dv_cnt;
      total = 0;
      bad = 0;
      reset = 1'b0;
      input_request = 1'b0;
      sign_extend_input = 1'b0;
      sw = '0;
      confirmation = 1'b0;
      tick(); tick(); tick();
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_outputs", {27'b0, data_valid, stall, waiting, timed_out, 1'b0}, 32'h0);
      reset = 1'b1;
      tick();
      chk("idle_stall", {31'b0, stall}, 32'd0);

      // Zero and sign extension.
      txn(16'h8001, 1'b0, 32'h0000_8001);
      txn(16'h8001, 1'b1, 32'hFFFF_8001);
      txn(16'h7ABC, 1'b1, 32'h0000_7ABC);

      // Button already held when the request rises: must be released and re-pressed.
      sign_extend_input = 1'b0;
      confirmation = 1'b1;
      sw = 16'h1111;
      tick(); tick(); tick();
      input_request = 1'b1;
      tick();
      repeat (4) tick();
      chk("held_on_entry_ignored", {31'b0, waiting}, 32'd1);
      confirmation = 1'b0;
      tick(); tick(); tick();
      chk("release_no_capture", {31'b0, waiting}, 32'd1);
      sw = 16'h0F0F;
      confirmation = 1'b1;
      tick(); tick(); tick();
      chk("repress_held", {31'b0, waiting}, 32'd0);
      sw = 16'hAAAA;
      confirmation = 1'b0;
      tick(); tick(); tick();
      chk("repress_valid", {31'b0, data_valid}, 32'd1);
      chk("repress_data", data_out, 32'h0000_0F0F);
      input_request = 1'b0;
      tick(); tick();

      // Abort in HELD: no delivery, data_out keeps its previous value.
      sw = 16'h1234;
      input_request = 1'b1;
      tick();
      confirmation = 1'b1;
      tick(); tick(); tick();
      chk("abort_held_in_held", {31'b0, stall}, 32'd1);
      input_request = 1'b0;
      tick();
      chk("abort_held_stall", {31'b0, stall}, 32'd0);
      confirmation = 1'b0;
      dv_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (data_valid) dv_cnt++;
      end
      chk("abort_held_no_valid", dv_cnt, 32'd0);
      chk("abort_held_data", data_out, 32'h0000_0F0F);

      // Abort and press edge in the same ARMED cycle: abort wins.
      sw = 16'h5555;
      input_request = 1'b1;
      tick();
      confirmation = 1'b1;
      tick(); tick();
      input_request = 1'b0;
      tick();
      chk("abort_race_stall", {31'b0, stall}, 32'd0);
      chk("abort_race_waiting", {31'b0, waiting}, 32'd0);
      confirmation = 1'b0;
      dv_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (data_valid) dv_cnt++;
      end
      chk("abort_race_no_valid", dv_cnt, 32'd0);
      chk("abort_race_data", data_out, 32'h0000_0F0F);

      // No press at all.
      input_request = 1'b1;
      tick();
`ifdef INPUT_CONFIRM_TIMEOUT_EN
      repeat (9) tick();
      chk("tmo_before_valid", {31'b0, data_valid}, 32'd0);
      chk("tmo_before_stall", {31'b0, stall}, 32'd1);
      tick();
      chk("tmo_valid", {31'b0, data_valid}, 32'd1);
      chk("tmo_flag", {31'b0, timed_out}, 32'd1);
      chk("tmo_data", data_out, 32'h0);
      chk("tmo_stall", {31'b0, stall}, 32'd0);
      tick();
      chk("tmo_flag_pulse", {31'b0, timed_out}, 32'd0);
      input_request = 1'b0;
      tick();
      txn(16'h00C3, 1'b0, 32'h0000_00C3);
      input_request = 1'b1;
      tick();
`else
      dv_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (stall !== 1'b1 || data_valid !== 1'b0 || timed_out !== 1'b0) dv_cnt++;
      end
      chk("no_timeout_1000", dv_cnt, 32'd0);
`endif

      // Asynchronous reset while stalled in ARMED.
      chk("pre_reset_stall", {31'b0, stall}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_outputs", {27'b0, data_valid, stall, waiting, timed_out, 1'b0}, 32'h0);
      chk("async_rst_data", data_out, 32'h0);
      input_request = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("post_reset_idle", {31'b0, stall}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_confirm_handshake.md
Name: input_confirm_handshake

Overview:
- Supplies the CPU's input-instruction path: it is the producer end of the IData channel that the CPU consumes.
- On a CPU input request it stalls the core and waits for the user to press and release the confirmation button.
- It then captures the switches, extends them to word width, and releases the core with a one-cycle valid strobe.
- Sits between the debounced buttons/switches and the memory data handler.

Parameters:
- IO_WIDTH, 16, width of switch input.
- WORD_SIZE, 32, width of delivered data word.
- TIMEOUT_CYCLES, 50000000, fast_clock cycles waited in ARMED before timeout (used only with the optional feature).

Ports:
- fast_clock  input  1  single clock for all state.
- reset  input  1  asynchronous, active-low reset.
- input_request  input  1  level; high while the CPU executes an input instruction.
- sign_extend_input  input  1  1 = sign-extend the switch value, 0 = zero-extend.
- sw  input  IO_WIDTH  raw switch value.
- confirmation  input  1  debounced button level; 1 = pressed.
- data_out  output  WORD_SIZE  delivered input word (IData).
- data_valid  output  1  one-cycle strobe when data_out is updated.
- stall  output  1  1 = hold CPU (drives enable low).
- waiting  output  1  1 while waiting for a button press (LED indicator).
- timed_out  output  1  1-cycle strobe on a timeout delivery; constant 0 without the macro.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; data_out=0, shadow=0; data_valid=0, stall=0, waiting=0, timed_out=0; synchronizer flops=0; timeout counter=0.
- confirmation passes through a 2-flop synchronizer. conf_rise = synced value is 1 and its previous value was 0.
- States and outputs are registered; transitions are evaluated each fast_clock edge.
- IDLE: stall=0.
  - If input_request=1, go to ARMED.
- ARMED: stall=1, waiting=1.
  - A button already held on entry is ignored; a fresh rising edge is required.
  - On conf_rise: capture sw into shadow, extended per sign_extend_input sampled the same cycle. Sign extension replicates sw[IO_WIDTH-1]. Then go to HELD.
  - If input_request drops: go to IDLE. No capture; data_out is unchanged.
- HELD: stall=1, waiting=0.
  - When synced confirmation=0, go to DELIVER.
  - If input_request drops: go to IDLE. Shadow is discarded; data_out is unchanged.
- DELIVER (1 cycle): data_out<=shadow, data_valid=1, stall=0, then go to DONE.
- DONE: stall=0; wait for input_request=0, then go to IDLE. This prevents re-arming on the same instruction.
- If input_request drop and conf_rise occur in the same cycle in ARMED, the abort wins.
- data_out holds its value between transactions; only DELIVER or a timeout changes it.
- Latency:
  - press to capture: 3 cycles (2 synchronizer + 1 edge).
  - release to data_valid: 3 cycles.
  - data_valid to stall low: same cycle.

Optional Feature:
- Macro: INPUT_CONFIRM_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ARMED and increments each ARMED cycle.
  - On reaching TIMEOUT_CYCLES-1 without a conf_rise, go to DELIVER with shadow=0. timed_out pulses alongside data_valid.
  - If conf_rise occurs in the expiry cycle, the press wins.
- Undefined: no counter; ARMED waits indefinitely; timed_out is tied to 0.

Test Plan:
- Reset mid-ARMED with stall=1 -> all outputs 0 immediately (asynchronous), state IDLE, data_out=0.
- input_request=1, sw=0x8001, sign_extend_input=0, press then release -> stall high throughout; data_valid pulses once with data_out=0x00008001; stall=0 in the same cycle.
- Same sequence with sign_extend_input=1 -> data_out=0xFFFF8001.
- Button held before input_request rises -> no capture until release and re-press; the value captured is sw at the second press.
- input_request dropped in HELD after a press with sw=0x1234 -> IDLE; no data_valid; data_out keeps its previous value.
- With INPUT_CONFIRM_TIMEOUT_EN and TIMEOUT_CYCLES=10, no press -> data_valid and timed_out pulse 10 cycles after ARMED entry; data_out=0; without the macro, stall stays 1 for 1000 cycles.
